// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU op classes and the decoded control bundle.
package mips_pkg;

   localparam logic [5:0] OP_R_TYPE = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SUB   = 3'b001;
   localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
   localparam logic [2:0] ALU_OP_ITYPE = 3'b011;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [2:0] alu_op;
   } ctrl_t;

   // Only R-type, beq and sw read rt as a source; for the rest rt is a destination.
   function automatic logic uses_rt(input logic [5:0] opcode);
      return (opcode == OP_R_TYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rt feeds the ID instruction.
module load_use_detect
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [5:0]            id_opcode,
   output logic                  load_use
);

   logic rs_hit, rt_hit;

   assign rs_hit   = (ex_rt == id_rs);
   assign rt_hit   = uses_rt(id_opcode) && (ex_rt == id_rt);
   assign load_use = ex_valid && ex_mem_read && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush-to-bubble and saturating debug counters.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_reg_dst,
   input  logic                  id_alu_src,
   input  logic                  id_mem_to_reg,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_branch,
   input  logic                  id_jump,
   input  logic [2:0]            id_alu_op,
   input  logic [5:0]            id_opcode,
   input  logic [5:0]            id_funct,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm_ext,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   output logic                  ex_reg_dst,
   output logic                  ex_alu_src,
   output logic                  ex_mem_to_reg,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic [2:0]            ex_alu_op,
   output logic [5:0]            ex_opcode,
   output logic [5:0]            ex_funct,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm_ext,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_valid,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   typedef struct packed {
      logic                  valid;
      ctrl_t                 ctrl;
      logic [5:0]            opcode;
      logic [5:0]            funct;
      logic [DATA_W-1:0]     pc_plus4;
      logic [DATA_W-1:0]     rs_data;
      logic [DATA_W-1:0]     rt_data;
      logic [DATA_W-1:0]     imm_ext;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
   } ex_t;

   ex_t              ex_q, ex_d, id_pkt;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
      .ex_valid    (ex_q.valid),
      .ex_mem_read (ex_q.ctrl.mem_read),
      .ex_rt       (ex_q.rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_opcode   (id_opcode),
      .load_use    (load_use)
   );

   // A flush kills the dependent instruction anyway, so it overrides the stall.
   assign stall       = load_use && !flush;
   assign pc_write    = !stall;
   assign if_id_write = !stall;

   always_comb begin
      id_pkt.valid           = 1'b1;
      id_pkt.ctrl.reg_dst    = id_reg_dst;
      id_pkt.ctrl.alu_src    = id_alu_src;
      id_pkt.ctrl.mem_to_reg = id_mem_to_reg;
      id_pkt.ctrl.reg_write  = id_reg_write;
      id_pkt.ctrl.mem_read   = id_mem_read;
      id_pkt.ctrl.mem_write  = id_mem_write;
      id_pkt.ctrl.branch     = id_branch;
      id_pkt.ctrl.jump       = id_jump;
      id_pkt.ctrl.alu_op     = id_alu_op;
      id_pkt.opcode          = id_opcode;
      id_pkt.funct           = id_funct;
      id_pkt.pc_plus4        = id_pc_plus4;
      id_pkt.rs_data         = id_rs_data;
      id_pkt.rt_data         = id_rt_data;
      id_pkt.imm_ext         = id_imm_ext;
      id_pkt.rs              = id_rs;
      id_pkt.rt              = id_rt;
      id_pkt.rd              = id_rd;
   end

   // Bubbles clear the whole packet, data included, so nothing stale reaches EX.
   always_comb begin
      ex_d        = '0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush) begin
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (stall) begin
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
         ex_d = id_pkt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_reg_dst    = ex_q.ctrl.reg_dst;
   assign ex_alu_src    = ex_q.ctrl.alu_src;
   assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
   assign ex_reg_write  = ex_q.ctrl.reg_write;
   assign ex_mem_read   = ex_q.ctrl.mem_read;
   assign ex_mem_write  = ex_q.ctrl.mem_write;
   assign ex_branch     = ex_q.ctrl.branch;
   assign ex_jump       = ex_q.ctrl.jump;
   assign ex_alu_op     = ex_q.ctrl.alu_op;
   assign ex_opcode     = ex_q.opcode;
   assign ex_funct      = ex_q.funct;
   assign ex_pc_plus4   = ex_q.pc_plus4;
   assign ex_rs_data    = ex_q.rs_data;
   assign ex_rt_data    = ex_q.rt_data;
   assign ex_imm_ext    = ex_q.imm_ext;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_rd         = ex_q.rd;
   assign stall_count   = stall_cnt_q;
   assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written corner sequences, random vs. model.
module tb_id_ex_stage;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs, rt, rd;
      logic [7:0]  c;   // reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump
      logic [2:0]  aop;
      logic [31:0] pc, a, b, imm;
   } instr_t;

   typedef struct {
      instr_t in;
      bit     fl;
      bit     exp_stall;
      bit     exp_vld;
   } vec_t;

   localparam logic [7:0] C_R   = 8'b1001_0000;
   localparam logic [7:0] C_LW  = 8'b0111_1000;
   localparam logic [7:0] C_IMM = 8'b0101_0000;
   localparam logic [7:0] C_SW  = 8'b0100_0100;

   logic clk = 1'b0;
   logic rst_n;
   logic id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
   logic [2:0] id_alu_op;
   logic [5:0] id_opcode, id_funct;
   logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
   logic [4:0] id_rs, id_rt, id_rd;
   logic flush;
   logic ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
   logic [2:0] ex_alu_op;
   logic [5:0] ex_opcode, ex_funct;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
   logic [4:0] ex_rs, ex_rt, ex_rd;
   logic ex_valid, pc_write, if_id_write, stall;
   logic [15:0] stall_count, flush_count;
   logic pc_write2, if_id_write2, stall2;
   logic [1:0] stall_count2, flush_count2;

   int checks = 0;
   int errors = 0;

   // Reference model: what EX should hold and how many events have happened.
   instr_t ex_m;
   bit     vm;
   bit     known;
   int     fc, sc;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
      .id_opcode(id_opcode), .id_funct(id_funct), .id_pc_plus4(id_pc_plus4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
      .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // Narrow-counter copy sharing the same stimulus, for saturation.
   logic ex2_reg_dst, ex2_alu_src, ex2_mem_to_reg, ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_branch, ex2_jump;
   logic [2:0] ex2_alu_op;
   logic [5:0] ex2_opcode, ex2_funct;
   logic [31:0] ex2_pc_plus4, ex2_rs_data, ex2_rt_data, ex2_imm_ext;
   logic [4:0] ex2_rs, ex2_rt, ex2_rd;
   logic ex2_valid;

   id_ex_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
      .id_opcode(id_opcode), .id_funct(id_funct), .id_pc_plus4(id_pc_plus4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_reg_dst(ex2_reg_dst), .ex_alu_src(ex2_alu_src), .ex_mem_to_reg(ex2_mem_to_reg),
      .ex_reg_write(ex2_reg_write), .ex_mem_read(ex2_mem_read), .ex_mem_write(ex2_mem_write),
      .ex_branch(ex2_branch), .ex_jump(ex2_jump), .ex_alu_op(ex2_alu_op),
      .ex_opcode(ex2_opcode), .ex_funct(ex2_funct), .ex_pc_plus4(ex2_pc_plus4),
      .ex_rs_data(ex2_rs_data), .ex_rt_data(ex2_rt_data), .ex_imm_ext(ex2_imm_ext),
      .ex_rs(ex2_rs), .ex_rt(ex2_rt), .ex_rd(ex2_rd), .ex_valid(ex2_valid),
      .pc_write(pc_write2), .if_id_write(if_id_write2), .stall(stall2),
      .stall_count(stall_count2), .flush_count(flush_count2)
   );

   function automatic instr_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [7:0] c, input logic [2:0] aop,
                                 input logic [31:0] imm);
      instr_t i;
      i.op = op; i.fn = 6'($urandom); i.rs = rs; i.rt = rt; i.rd = rd; i.c = c; i.aop = aop;
      i.pc = $urandom; i.a = $urandom; i.b = $urandom; i.imm = imm;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      logic [5:0] ops [11];
      instr_t i;
      ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      i = mk(ops[$urandom_range(10)], 5'($urandom_range(3)), 5'($urandom_range(3)),
             5'($urandom), 8'($urandom), 3'($urandom), $urandom);
      i.c[3] = (i.op == 6'h23) || ($urandom_range(7) == 0);
      return i;
   endfunction

   function automatic logic [166:0] pk(input bit v, input instr_t i);
      if (!v) return '0;
      return {1'b1, i.c, i.aop, i.op, i.fn, i.pc, i.a, i.b, i.imm, i.rs, i.rt, i.rd};
   endfunction

   function automatic bit model_stall(input instr_t in, input bit fl);
      bit reads_rt;
      reads_rt = (in.op == 6'h00) || (in.op == 6'h04) || (in.op == 6'h2B);
      return vm && ex_m.c[3] && (ex_m.rt != 0) &&
             ((ex_m.rt == in.rs) || (reads_rt && ex_m.rt == in.rt)) && !fl;
   endfunction

   task automatic check(input string name, input logic [166:0] act, input logic [166:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input instr_t i, input bit fl, input bit rn);
      {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump} = i.c;
      id_alu_op = i.aop; id_opcode = i.op; id_funct = i.fn; id_pc_plus4 = i.pc;
      id_rs_data = i.a; id_rt_data = i.b; id_imm_ext = i.imm;
      id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; flush = fl; rst_n = rn;
   endtask

   // One cycle: drive, check hazard outputs, clock, advance model, check EX and counters.
   task automatic step(input instr_t in, input bit fl, input bit rn, output bit st_o, output bit vld_o);
      bit es;
      drive(in, fl, rn);
      #2;
      es = model_stall(in, fl);
      if (known) begin
         check("hazard", 167'({stall, pc_write, if_id_write}), 167'({es, !es, !es}));
         check("hazard_w2", 167'({stall2, pc_write2}), 167'({es, !es}));
      end
      st_o = stall;
      if (!rn) begin
         vm = 0; fc = 0; sc = 0; known = 1;
      end else if (fl) begin
         vm = 0; fc++;
      end else if (es) begin
         vm = 0; sc++;
      end else begin
         vm = 1; ex_m = in;
      end
      @(posedge clk);
      #1;
      check("ex_bundle", {ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                          ex_mem_write, ex_branch, ex_jump, ex_alu_op, ex_opcode, ex_funct, ex_pc_plus4,
                          ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd}, pk(vm, ex_m));
      check("counters", 167'({stall_count, flush_count}),
            167'({16'(sc > 65535 ? 65535 : sc), 16'(fc > 65535 ? 65535 : fc)}));
      check("counters_w2", 167'({stall_count2, flush_count2}),
            167'({2'(sc > 3 ? 3 : sc), 2'(fc > 3 ? 3 : fc)}));
      vld_o = ex_valid;
   endtask

   initial begin
      vec_t   tbl [14];
      instr_t i;
      bit     st, vl;

      tbl[0]  = '{mk(6'h08, 5'd1, 5'd5, 5'd0, C_IMM, 3'b000, 32'h10), 0, 0, 1};
      tbl[1]  = '{mk(6'h23, 5'd2, 5'd8, 5'd0, C_LW, 3'b000, 32'h4), 0, 0, 1};
      tbl[2]  = '{mk(6'h00, 5'd8, 5'd9, 5'd10, C_R, 3'b010, 32'h0), 0, 1, 0};
      tbl[3]  = tbl[2]; tbl[3].exp_stall = 0; tbl[3].exp_vld = 1;
      tbl[4]  = '{mk(6'h23, 5'd2, 5'd8, 5'd0, C_LW, 3'b000, 32'h8), 0, 0, 1};
      tbl[5]  = '{mk(6'h0D, 5'd3, 5'd8, 5'd0, C_IMM, 3'b011, 32'hff), 0, 0, 1};
      tbl[6]  = '{mk(6'h23, 5'd2, 5'd8, 5'd0, C_LW, 3'b000, 32'hc), 0, 0, 1};
      tbl[7]  = '{mk(6'h2B, 5'd3, 5'd8, 5'd0, C_SW, 3'b000, 32'h0), 0, 1, 0};
      tbl[8]  = tbl[7]; tbl[8].exp_stall = 0; tbl[8].exp_vld = 1;
      tbl[9]  = '{mk(6'h23, 5'd1, 5'd0, 5'd0, C_LW, 3'b000, 32'h0), 0, 0, 1};
      tbl[10] = '{mk(6'h00, 5'd0, 5'd0, 5'd4, C_R, 3'b010, 32'h0), 0, 0, 1};
      tbl[11] = '{mk(6'h23, 5'd2, 5'd8, 5'd0, C_LW, 3'b000, 32'h0), 0, 0, 1};
      tbl[12] = '{mk(6'h00, 5'd8, 5'd9, 5'd10, C_R, 3'b010, 32'h0), 1, 0, 0};
      tbl[13] = '{mk(6'h08, 5'd8, 5'd7, 5'd0, C_IMM, 3'b000, 32'h1), 0, 0, 1};

      known = 0; vm = 0; fc = 0; sc = 0; ex_m = mk(0, 0, 0, 0, 0, 0, 0);

      // Reset held two cycles under random inputs.
      for (int k = 0; k < 2; k++) step(rnd_instr(), 1'($urandom), 0, st, vl);
      check("rst_hazard", 167'({stall, pc_write, if_id_write}), 167'(3'b011));

      for (int k = 0; k < 14; k++) begin
         step(tbl[k].in, tbl[k].fl, 1, st, vl);
         check($sformatf("tbl%0d_stall", k), 167'(st), 167'(tbl[k].exp_stall));
         check($sformatf("tbl%0d_vld", k), 167'(vl), 167'(tbl[k].exp_vld));
      end
      check("tbl_counts", 167'({stall_count, flush_count}), 167'({16'd2, 16'd1}));

      // Reset landing on a stall cycle: EX clears and the stall drops.
      i = mk(6'h23, 5'd2, 5'd8, 5'd0, C_LW, 3'b000, 32'h0);
      step(i, 0, 1, st, vl);
      i = mk(6'h00, 5'd8, 5'd9, 5'd10, C_R, 3'b010, 32'h0);
      step(i, 0, 0, st, vl);
      check("rst_mid_stall_pre", 167'(st), 167'(1));
      check("rst_mid_stall_post", 167'({stall, ex_valid, stall_count}), 167'(0));

      // Saturation: five flushes.
      for (int k = 0; k < 5; k++) step(rnd_instr(), 1, 1, st, vl);
      check("sat_w2", 167'(flush_count2), 167'(2'd3));
      check("sat_w16", 167'(flush_count), 167'(16'd5));

      // Random traffic against the model.
      for (int k = 0; k < 400; k++)
         step(rnd_instr(), $urandom_range(7) == 0, $urandom_range(49) != 0, st, vl);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
